// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sine generator: quadrant encoding,
// default/derived widths and the elaboration-time quarter-wave table generator.
package dds_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam int DEF_ROM_WIDTH = 8;
    localparam int DEF_ROM_DEPTH = 64;
    localparam int ADDR_W        = $clog2(DEF_ROM_DEPTH);
    localparam int OUT_W         = DEF_ROM_WIDTH + 1;

    localparam real PI_HALF = 1.5707963267948966;

    // round((2^width-1) * sin(pi/2 * (k+0.5)/depth)); the sine is a Taylor
    // series so the table can be folded to constants during elaboration.
    function automatic int rom_entry(input int k, input int depth, input int width);
        real x;
        real term;
        real s;
        x    = PI_HALF * (real'(k) + 0.5) / real'(depth);
        term = x;
        s    = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi(s * real'((1 << width) - 1) + 0.5);
    endfunction

endpackage

// File: rtl/dds_quarter_rom.sv
// Quarter-wave sine table with registered read and NUM_PORTS independent
// read ports (two when the cosine path is built, one otherwise).
module dds_quarter_rom
    import dds_pkg::*;
#(
    parameter int ROM_WIDTH = DEF_ROM_WIDTH,
    parameter int ROM_DEPTH = DEF_ROM_DEPTH,
    parameter int NUM_PORTS = 2,
    localparam int AW       = $clog2(ROM_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0][AW-1:0]         addr,
    output logic [NUM_PORTS-1:0][ROM_WIDTH-1:0]  data
);

    logic [ROM_WIDTH-1:0] tbl [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_tbl
        localparam int V = rom_entry(k, ROM_DEPTH, ROM_WIDTH);
        assign tbl[k] = ROM_WIDTH'(V);
    end

    // One registered read per port every clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) data[p] <= tbl[addr[p]];
        end
    end

endmodule

// File: rtl/dds_phase_controller.sv
// DDS sine generator: divided sample strobe, phase accumulator with shadowed
// ftw/phase_offset handshake, sticky phase sync, quarter-wave folding.
// Optional cosine output built when DDS_QUADRATURE_EN is defined.
module dds_phase_controller
    import dds_pkg::*;
#(
    parameter int ROM_WIDTH   = DEF_ROM_WIDTH,
    parameter int ROM_DEPTH   = DEF_ROM_DEPTH,
    parameter int PHASE_WIDTH = 32,
    parameter int CE_DIV      = 390
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PHASE_WIDTH-1:0]        ftw,
    input  logic [PHASE_WIDTH-1:0]        phase_offset,
    input  logic                          ftw_valid,
    output logic                          ftw_ready,
    input  logic                          phase_sync,
    output logic signed [ROM_WIDTH:0]     o_sin,
    output logic signed [ROM_WIDTH:0]     o_cos,
    output logic                          o_ce
);

    localparam int AW     = $clog2(ROM_DEPTH);
    localparam int OW     = ROM_WIDTH + 1;
    localparam int CW     = $clog2(CE_DIV);
    localparam int STAGES = 2;
`ifdef DDS_QUADRATURE_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    typedef struct packed {
        logic          neg;
        logic [AW-1:0] addr;
    } fold_t;

    logic [CW-1:0]          cnt;
    logic                   tick;
    logic                   shadow_full;
    logic [PHASE_WIDTH-1:0] sh_ftw, sh_off, act_ftw, act_off;
    logic                   sync_req;
    logic [PHASE_WIDTH-1:0] acc, acc_nxt;
    fold_t [NP-1:0]         fold_nxt, fold_q;
    logic [NP-1:0]          neg_d;
    logic [NP-1:0][AW-1:0]        rom_addr;
    logic [NP-1:0][ROM_WIDTH-1:0] rom_data;
    logic [NP-1:0][OW-1:0]        samp_nxt, samp_q;
    logic [STAGES:0]        vld_pipe;

    // Quadrant folding of the top AW+2 phase bits; mirror is D-1-i == ~i.
    function automatic fold_t fold(input logic [AW+1:0] ph);
        quad_e q;
        fold_t f;
        q      = quad_e'(ph[AW+1:AW]);
        f.neg  = (q == QUAD_2) || (q == QUAD_3);
        f.addr = ((q == QUAD_1) || (q == QUAD_3)) ? ~ph[AW-1:0] : ph[AW-1:0];
        return f;
    endfunction

    assign tick      = (cnt == CW'(CE_DIV - 1));
    assign ftw_ready = !shadow_full;

    // Sample strobe divider: one tick per CE_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Shadow capture on handshake; emptied by the tick that applies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_full <= 1'b0;
            sh_ftw      <= '0;
            sh_off      <= '0;
        end else if (ftw_valid && !shadow_full) begin
            shadow_full <= 1'b1;
            sh_ftw      <= ftw;
            sh_off      <= phase_offset;
        end else if (tick) begin
            shadow_full <= 1'b0;
        end
    end

    // Pending shadow becomes active after the current tick has used the old one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_ftw <= '0;
            act_off <= '0;
        end else if (tick && shadow_full) begin
            act_ftw <= sh_ftw;
            act_off <= sh_off;
        end
    end

    // Sticky sync request; a pulse in a tick cycle survives to the next tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            sync_req <= 1'b0;
        else if (tick)       sync_req <= phase_sync;
        else if (phase_sync) sync_req <= 1'b1;
    end

    // Next phase and its fold for each output path (cosine leads by a quarter).
    always_comb begin
        acc_nxt  = sync_req ? act_off : acc + act_ftw;
        fold_nxt = '0;
        for (int p = 0; p < NP; p++)
            fold_nxt[p] = fold(acc_nxt[PHASE_WIDTH-1 -: AW+2] + ((AW+2)'(p) << AW));
    end

    // Accumulator and folded address update together on the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            fold_q <= '0;
        end else if (tick) begin
            acc    <= acc_nxt;
            fold_q <= fold_nxt;
        end
    end

    // Sign bit travels alongside the ROM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_d    <= '0;
            vld_pipe <= '0;
        end else begin
            for (int p = 0; p < NP; p++) neg_d[p] <= fold_q[p].neg;
            vld_pipe <= {vld_pipe[STAGES-1:0], tick};
        end
    end

    // ROM address ports fed straight from the fold registers.
    always_comb begin
        rom_addr = '0;
        for (int p = 0; p < NP; p++) rom_addr[p] = fold_q[p].addr;
    end

    dds_quarter_rom #(
        .ROM_WIDTH (ROM_WIDTH),
        .ROM_DEPTH (ROM_DEPTH),
        .NUM_PORTS (NP)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Apply sign as two's complement over OW bits.
    always_comb begin
        samp_nxt = '0;
        for (int p = 0; p < NP; p++)
            samp_nxt[p] = neg_d[p] ? -{1'b0, rom_data[p]} : {1'b0, rom_data[p]};
    end

    // Output register: loads once per sample, holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             samp_q <= '0;
        else if (vld_pipe[1]) samp_q <= samp_nxt;
    end

    assign o_ce  = vld_pipe[STAGES];
    assign o_sin = samp_q[0];
`ifdef DDS_QUADRATURE_EN
    assign o_cos = samp_q[NP-1];
`else
    assign o_cos = '0;
`endif

endmodule

// File: tb/tb_dds_phase_controller.sv
// Self-checking bench for dds_phase_controller: directed scenarios plus
// random ftw/phase/sync traffic against a transaction-level sine model.
module tb_dds_phase_controller;

    localparam int  RW = 8;
    localparam int  RD = 64;
    localparam int  PW = 32;
    localparam int  CE = 40;
    localparam real PI = 3.14159265358979323846;
    localparam longint unsigned M = 64'd1 << PW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [PW-1:0] ftw = '0, phase_offset = '0;
    logic ftw_valid = 1'b0, phase_sync = 1'b0;
    logic ftw_ready, o_ce;
    logic signed [RW:0] o_sin, o_cos;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dds_phase_controller #(
        .ROM_WIDTH   (RW),
        .ROM_DEPTH   (RD),
        .PHASE_WIDTH (PW),
        .CE_DIV      (CE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ftw          (ftw),
        .phase_offset (phase_offset),
        .ftw_valid    (ftw_valid),
        .ftw_ready    (ftw_ready),
        .phase_sync   (phase_sync),
        .o_sin        (o_sin),
        .o_cos        (o_cos),
        .o_ce         (o_ce)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rom_ref(input int k);
        return $rtoi((2.0 ** RW - 1.0) * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(RD)) + 0.5);
    endfunction

    // Signed sine sample for a phase in [0, 2^PW), straight from the quadrant rules.
    function automatic int sample_of(input longint unsigned ph);
        longint unsigned quarter = 64'd1 << (PW - 2);
        int q   = int'(ph / quarter);
        int i   = int'((ph % quarter) / (quarter / RD));
        int mag = (q % 2 == 1) ? rom_ref(RD - 1 - i) : rom_ref(i);
        return (q >= 2) ? -mag : mag;
    endfunction

    typedef struct {
        int due;
        int s;
        int c;
    } smp_t;

    smp_t pipe[$];
    longint unsigned m_phase, m_ftw, m_off, s_ftw, s_off;
    bit m_pend, m_sync, pend_old, e_ce;
    int cyc, e_sin, e_cos;

    // Per-cycle check, then advance the model by the inputs seen this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ce", o_ce, 0);
            chk("rst_sin", o_sin, 0);
            chk("rst_cos", o_cos, 0);
            chk("rst_ready", ftw_ready, 1);
            pipe.delete();
            m_phase = 0; m_ftw = 0; m_off = 0; s_ftw = 0; s_off = 0;
            m_pend = 0; m_sync = 0; cyc = 0; e_sin = 0; e_cos = 0;
        end else begin
            e_ce = 0;
            if (pipe.size() > 0 && pipe[0].due == cyc) begin
                e_ce  = 1;
                e_sin = pipe[0].s;
                e_cos = pipe[0].c;
                void'(pipe.pop_front());
            end
            chk("ce", o_ce, e_ce);
            chk("sin", o_sin, e_sin);
            chk("cos", o_cos, e_cos);
            chk("ready", ftw_ready, !m_pend);
            pend_old = m_pend;
            if (cyc % CE == CE - 1) begin
                smp_t e;
                m_phase = m_sync ? m_off : (m_phase + m_ftw) % M;
                e.due = cyc + 3;
                e.s   = sample_of(m_phase);
`ifdef DDS_QUADRATURE_EN
                e.c   = sample_of((m_phase + M / 4) % M);
`else
                e.c   = 0;
`endif
                pipe.push_back(e);
                m_sync = phase_sync;
                if (pend_old) begin
                    m_ftw  = s_ftw;
                    m_off  = s_off;
                    m_pend = 0;
                end
            end else begin
                m_sync = m_sync | phase_sync;
            end
            if (ftw_valid && !pend_old) begin
                m_pend = 1;
                s_ftw  = ftw;
                s_off  = phase_offset;
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ce(output logic signed [RW:0] s, output int n);
        n = 0;
        s = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ce && n < 2 * CE + 8);
        if (!o_ce) chk("ce_timeout", o_ce, 1);
        s = o_sin;
    endtask

    task automatic wait_slot(input int v);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (cyc % CE != v && k < 3 * CE);
        if (cyc % CE != v) chk("slot_timeout", cyc % CE, v);
    endtask

    task automatic wait_ready();
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!ftw_ready && k < 3 * CE);
        if (!ftw_ready) chk("ready_timeout", ftw_ready, 1);
    endtask

    task automatic offer(input logic [PW-1:0] f, input logic [PW-1:0] o);
        wait_ready();
        ftw = f;
        phase_offset = o;
        ftw_valid = 1'b1;
        @(posedge clk); #1;
        ftw_valid = 1'b0;
        chk("ready_drop", ftw_ready, 0);
    endtask

    task automatic sync_pulse();
        phase_sync = 1'b1;
        @(posedge clk); #1;
        phase_sync = 1'b0;
    endtask

    int seq4 [5] = '{3, 255, -3, -255, 3};
    int sweep [257];

    initial begin
        logic signed [RW:0] s;
        int n, maxd, d;

        // Reset, then defaults: ftw = 0 gives rom[0] every CE clocks.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_ce(s, n);
        chk("first_ce_latency", n, CE + 3);
        chk("default_sin", s, 3);
`ifdef DDS_QUADRATURE_EN
        chk("default_cos", o_cos, 255);
`else
        chk("default_cos", o_cos, 0);
`endif
        wait_ce(s, n);
        chk("ce_period", n, CE);
        chk("default_sin2", s, 3);

        // Quarter-cycle steps.
        offer(32'h4000_0000, '0);
        wait_ready();
        for (int k = 0; k < 5; k++) begin
            wait_ce(s, n);
            chk($sformatf("quarter_seq%0d", k), s, seq4[k]);
        end

        // Offer coinciding with a tick; second offer refused while pending.
        wait_slot(CE - 1);
        ftw = 32'h1000_0000;
        phase_offset = '0;
        ftw_valid = 1'b1;
        @(negedge clk);
        chk("tick_offer_ready", ftw_ready, 1);
        @(posedge clk); #1;
        ftw = 32'h0123_4567;
        chk("second_offer_blocked", ftw_ready, 0);
        repeat (4) begin
            @(posedge clk); #1;
            ftw = $urandom;
        end
        ftw_valid = 1'b0;
        wait_ready();

        // Phase sync to half cycle: accumulator loads the offset, no add.
        offer(32'h4000_0000, 32'h8000_0000);
        wait_ready();
        wait_slot(0);
        sync_pulse();
        wait_slot(4);
        wait_ce(s, n);
        chk("sync_sample", s, -3);
        wait_ce(s, n);
        chk("sync_next", s, -255);

        // Fine sweep: one table index per sample across a full cycle.
        offer(32'h0100_0000, '0);
        wait_ready();
        wait_slot(0);
        sync_pulse();
        wait_slot(4);
        for (int k = 0; k < 257; k++) begin
            wait_ce(s, n);
            sweep[k] = s;
        end
        chk("sweep_0", sweep[0], 3);
        chk("sweep_63", sweep[63], 255);
        chk("sweep_64", sweep[64], 255);
        chk("sweep_127", sweep[127], 3);
        chk("sweep_128", sweep[128], -3);
        chk("sweep_192", sweep[192], -255);
        chk("sweep_wrap", sweep[256], 3);
        maxd = 0;
        for (int k = 1; k < 257; k++) begin
            d = sweep[k] - sweep[k-1];
            if (d < 0) d = -d;
            if (d > maxd) maxd = d;
        end
        chk("sweep_continuity", maxd <= 7, 1);

        // Random ftw/offset offers and sync pulses.
        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 2);
            repeat ($urandom_range(0, CE)) @(posedge clk);
            #1;
            if (r == 0) begin
                ftw_valid = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    ftw = $urandom;
                    phase_offset = $urandom;
                    @(posedge clk); #1;
                end
                ftw_valid = 1'b0;
            end else if (r == 1) begin
                sync_pulse();
            end
        end

        // Reset one clock after a tick with a shadow and a sync pending.
        wait_ready();
        wait_slot(CE - 1);
        ftw = 32'h4000_0000;
        phase_offset = 32'h8000_0000;
        ftw_valid = 1'b1;
        phase_sync = 1'b1;
        @(posedge clk); #1;
        ftw_valid = 1'b0;
        phase_sync = 1'b0;
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_ce) n++;
        end
        chk("reset_no_ce", n, 0);
        chk("reset_sin", o_sin, 0);
        chk("reset_ready", ftw_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ce(s, n);
        chk("post_reset_latency", n, CE + 3);
        chk("post_reset_sin", s, 3);
        wait_ce(s, n);
        chk("post_reset_sin2", s, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
